// File: rtl/dsp_sched_pkg.sv
// Shared types and constants for the multi-channel DSP block scheduler.
// Mode codes select the engine operation latched into each dispatched job.
package dsp_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [1:0] MODE_FIR      = 2'b00;
  localparam logic [1:0] MODE_FFT      = 2'b01;
  localparam logic [1:0] MODE_FFT_IFFT = 2'b10;
  localparam logic [1:0] MODE_BYPASS   = 2'b11;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int NUM_CH_DEF     = 4;
  localparam int BLOCK_SIZE_DEF = 16;
  localparam int MODE_W_DEF     = 2;

  localparam int CH_W  = $clog2(NUM_CH_DEF);
  localparam int IDX_W = $clog2(BLOCK_SIZE_DEF);

endpackage

// File: rtl/dsp_block_scheduler_if.sv
// Ingress, configuration and engine-side signals of dsp_block_scheduler.
// The master side drives samples/config/engine responses; the slave is the scheduler.
interface dsp_block_scheduler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int BLOCK_SIZE = 16,
  parameter int MODE_W     = 2
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int IDX_W = $clog2(BLOCK_SIZE);

  logic                  valid_in;
  logic [CH_W-1:0]       ch_in;
  logic [DATA_WIDTH-1:0] sample_in;
  logic                  cfg_we;
  logic [CH_W-1:0]       cfg_ch;
  logic [MODE_W-1:0]     cfg_mode;
  logic                  ovf_clear;
  logic                  start_job;
  logic [CH_W-1:0]       job_ch;
  logic                  job_bank;
  logic [MODE_W-1:0]     job_mode;
  logic                  job_done;
  logic                  rd_en;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  processing_active;
  logic [NUM_CH-1:0]     overflow;
  logic [15:0]           blocks_done;

  modport master (
    output valid_in, ch_in, sample_in, cfg_we, cfg_ch, cfg_mode, ovf_clear,
    output job_done, rd_en, rd_idx,
    input  start_job, job_ch, job_bank, job_mode, rd_data, rd_valid,
    input  processing_active, overflow, blocks_done
  );

  modport slave (
    input  valid_in, ch_in, sample_in, cfg_we, cfg_ch, cfg_mode, ovf_clear,
    input  job_done, rd_en, rd_idx,
    output start_job, job_ch, job_bank, job_mode, rd_data, rd_valid,
    output processing_active, overflow, blocks_done
  );

endinterface

// File: rtl/pingpong_bank.sv
// One channel's ping-pong sample storage: two blocks, a fill pointer and per-bank occupancy.
// A full block stays occupied until the scheduler releases it after the engine finishes.
module pingpong_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int BLOCK_SIZE = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_wrEn,
  input  logic [DATA_WIDTH-1:0]         i_wrData,
  input  logic                          i_relEn,
  input  logic                          i_relBank,
  input  logic                          i_rdBank,
  input  logic [$clog2(BLOCK_SIZE)-1:0] i_rdIdx,
  output logic [1:0]                    o_occupied,
  output logic                          o_drop,
  output logic [DATA_WIDTH-1:0]         o_rdData
);
  localparam int IDX_W = $clog2(BLOCK_SIZE);

  logic [DATA_WIDTH-1:0] r_mem [2][BLOCK_SIZE];
  logic [IDX_W-1:0]      r_wrPtr;
  logic                  r_wrBank;
  logic [1:0]            r_occupied;
  logic                  w_free;
  logic                  w_accept;
  logic                  w_lastWord;

  // A release landing on the bank being filled frees it in time for this sample.
  always_comb begin
    w_free     = !r_occupied[r_wrBank] || (i_relEn && (i_relBank == r_wrBank));
    w_accept   = i_wrEn && w_free;
    w_lastWord = (r_wrPtr == IDX_W'(BLOCK_SIZE - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_wrBank   <= 1'b0;
      r_occupied <= 2'b00;
    end else begin
      if (i_relEn) begin
        r_occupied[i_relBank] <= 1'b0;
      end
      if (w_accept) begin
        r_wrPtr <= r_wrPtr + 1'b1;
        if (w_lastWord) begin
          r_occupied[r_wrBank] <= 1'b1;
          r_wrBank             <= ~r_wrBank;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wrBank][r_wrPtr] <= i_wrData;
    end
  end

  assign o_occupied = r_occupied;
  assign o_drop     = i_wrEn && !w_free;
  assign o_rdData   = r_mem[i_rdBank][i_rdIdx];

endmodule

// File: rtl/dsp_block_scheduler.sv
// Collects per-channel sample blocks and dispatches them one at a time to a shared engine.
// Round-robin grant among channels whose oldest unserved bank is full.
module dsp_block_scheduler
  import dsp_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
  parameter int MODE_W     = MODE_W_DEF
) (
  input logic                 clk,
  input logic                 reset,
  dsp_block_scheduler_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);

  state_t                r_state;
  state_t                w_nextState;
  logic [1:0]            w_occ [NUM_CH];
  logic [DATA_WIDTH-1:0] w_bankRd [NUM_CH];
  logic [NUM_CH-1:0]     w_eligible;
  logic [NUM_CH-1:0]     w_drop;
  logic [NUM_CH-1:0]     r_serveBank;
  logic [MODE_W-1:0]     r_mode [NUM_CH];
  logic [CH_W-1:0]       r_rrPtr;
  logic [CH_W-1:0]       w_candidate;
  logic [CH_W-1:0]       w_grantCh;
  logic                  w_grant;
  logic                  w_release;
  logic                  r_startJob;
  logic [CH_W-1:0]       r_jobCh;
  logic                  r_jobBank;
  logic [MODE_W-1:0]     r_jobMode;
  logic [DATA_WIDTH-1:0] r_rdData;
  logic                  r_rdValid;
  logic [NUM_CH-1:0]     r_overflow;
  logic [15:0]           r_blocksDone;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic w_wrEn;
    logic w_relEn;

    assign w_wrEn  = bus.valid_in && (bus.ch_in == CH_W'(g));
    assign w_relEn = w_release && (r_jobCh == CH_W'(g));

    pingpong_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .BLOCK_SIZE(BLOCK_SIZE)
    ) u_bank (
      .clk       (clk),
      .reset     (reset),
      .i_wrEn    (w_wrEn),
      .i_wrData  (bus.sample_in),
      .i_relEn   (w_relEn),
      .i_relBank (r_jobBank),
      .i_rdBank  (r_jobBank),
      .i_rdIdx   (bus.rd_idx),
      .o_occupied(w_occ[g]),
      .o_drop    (w_drop[g]),
      .o_rdData  (w_bankRd[g])
    );

    assign w_eligible[g] = w_occ[g][r_serveBank[g]];
  end

  // Next state plus the arbiter: first eligible channel at or after r_rrPtr wins.
  always_comb begin
    w_nextState = r_state;
    w_grant     = 1'b0;
    w_grantCh   = '0;
    w_release   = 1'b0;
    w_candidate = '0;
    case (r_state)
      IDLE: begin
        for (int i = 0; i < NUM_CH; i++) begin
          w_candidate = r_rrPtr + CH_W'(i);
          if (!w_grant && w_eligible[w_candidate]) begin
            w_grant   = 1'b1;
            w_grantCh = w_candidate;
          end
        end
        if (w_grant) begin
          w_nextState = BUSY;
        end
      end
      BUSY: begin
        if (bus.job_done) begin
          w_release   = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_startJob   <= 1'b0;
      r_jobCh      <= '0;
      r_jobBank    <= 1'b0;
      r_jobMode    <= '0;
      r_rrPtr      <= '0;
      r_serveBank  <= '0;
      r_blocksDone <= '0;
      r_overflow   <= '0;
      r_rdData     <= '0;
      r_rdValid    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_mode[i] <= MODE_W'(MODE_FIR);
      end
    end else begin
      r_state    <= w_nextState;
      r_startJob <= w_grant;
      if (w_grant) begin
        r_jobCh   <= w_grantCh;
        r_jobBank <= r_serveBank[w_grantCh];
        r_jobMode <= r_mode[w_grantCh];
        r_rrPtr   <= w_grantCh + 1'b1;
      end
      if (w_release) begin
        r_serveBank[r_jobCh] <= ~r_serveBank[r_jobCh];
        r_blocksDone         <= r_blocksDone + 16'd1;
      end
      if (bus.cfg_we) begin
        r_mode[bus.cfg_ch] <= bus.cfg_mode;
      end
      // A drop in the same cycle as a clear leaves that channel's flag set.
      r_overflow <= (bus.ovf_clear ? '0 : r_overflow) | w_drop;
      if (bus.rd_en && (r_state == BUSY)) begin
        r_rdData  <= w_bankRd[r_jobCh];
        r_rdValid <= 1'b1;
      end else begin
        r_rdValid <= 1'b0;
      end
    end
  end

  assign bus.start_job         = r_startJob;
  assign bus.job_ch            = r_jobCh;
  assign bus.job_bank          = r_jobBank;
  assign bus.job_mode          = r_jobMode;
  assign bus.rd_data           = r_rdData;
  assign bus.rd_valid          = r_rdValid;
  assign bus.processing_active = (r_state == BUSY);
  assign bus.overflow          = r_overflow;
  assign bus.blocks_done       = r_blocksDone;

endmodule

// File: tb/tb_dsp_block_scheduler.sv
// Self-checking bench for dsp_block_scheduler: a queue-based block model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_dsp_block_scheduler;
  import dsp_sched_pkg::*;

  localparam int DATA_WIDTH = 16;
  localparam int NUM_CH     = 4;
  localparam int BLOCK_SIZE = 16;
  localparam int MODE_W     = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dsp_block_scheduler_if #(
    .DATA_WIDTH(DATA_WIDTH), .NUM_CH(NUM_CH), .BLOCK_SIZE(BLOCK_SIZE), .MODE_W(MODE_W)
  ) bus ();

  dsp_block_scheduler #(
    .DATA_WIDTH(DATA_WIDTH), .NUM_CH(NUM_CH), .BLOCK_SIZE(BLOCK_SIZE), .MODE_W(MODE_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int vecCount = 0;
  int missCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: each channel owns a queue of complete, unretired blocks (at most two fit)
  // plus a partial block being filled. The engine serves the oldest block of a channel.
  typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] blk_t;
  blk_t                  mQ [NUM_CH][$];
  blk_t                  mFill [NUM_CH];
  int                    mFillCnt [NUM_CH];
  int                    mServed [NUM_CH];
  logic [MODE_W-1:0]     mMode [NUM_CH];
  logic [NUM_CH-1:0]     mOvf;
  logic [NUM_CH-1:0]     newOvf;
  bit                    mBusy, mStart, mRdValid, relNow;
  int                    mJobCh, mJobBank, mRr, relCh, c;
  logic [MODE_W-1:0]     mJobMode;
  blk_t                  mJobBlk;
  logic [DATA_WIDTH-1:0] mRdData;
  logic [15:0]           mDone;

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        mQ[k].delete();
        mFillCnt[k] = 0;
        mServed[k]  = 0;
        mMode[k]    = MODE_FIR;
      end
      mOvf = '0; mBusy = 0; mStart = 0; mRdValid = 0;
      mJobCh = 0; mJobBank = 0; mRr = 0; mJobMode = '0; mRdData = '0; mDone = '0;
    end else begin
      relNow = mBusy && bus.job_done;
      relCh  = mJobCh;
      if (bus.rd_en && mBusy) begin
        mRdValid = 1;
        mRdData  = mJobBlk[bus.rd_idx];
      end else begin
        mRdValid = 0;
      end
      mStart = 0;
      if (relNow) begin
        void'(mQ[relCh].pop_front());
        mServed[relCh]++;
        mDone++;
        mBusy = 0;
      end else if (!mBusy) begin
        for (int i = 0; i < NUM_CH; i++) begin
          c = (mRr + i) % NUM_CH;
          if (!mStart && mQ[c].size() > 0) begin
            mStart   = 1;
            mBusy    = 1;
            mJobCh   = c;
            mJobBank = mServed[c] % 2;
            mJobMode = mMode[c];
            mJobBlk  = mQ[c][0];
            mRr      = (c + 1) % NUM_CH;
          end
        end
      end
      newOvf = bus.ovf_clear ? '0 : mOvf;
      if (bus.valid_in) begin
        c = int'(bus.ch_in);
        if (mQ[c].size() == 2) begin
          newOvf[c] = 1'b1;
        end else begin
          mFill[c][mFillCnt[c]] = bus.sample_in;
          mFillCnt[c]++;
          if (mFillCnt[c] == BLOCK_SIZE) begin
            mQ[c].push_back(mFill[c]);
            mFillCnt[c] = 0;
          end
        end
      end
      mOvf = newOvf;
      if (bus.cfg_we) mMode[bus.cfg_ch] = bus.cfg_mode;
    end
  end

  always @(posedge clk) begin
    #1;
    checkOutput("start_job", 32'(bus.start_job), 32'(mStart));
    checkOutput("processing_active", 32'(bus.processing_active), 32'(mBusy));
    checkOutput("job_ch", 32'(bus.job_ch), 32'(mJobCh));
    checkOutput("job_bank", 32'(bus.job_bank), 32'(mJobBank));
    checkOutput("job_mode", 32'(bus.job_mode), 32'(mJobMode));
    checkOutput("overflow", 32'(bus.overflow), 32'(mOvf));
    checkOutput("blocks_done", 32'(bus.blocks_done), 32'(mDone));
    checkOutput("rd_valid", 32'(bus.rd_valid), 32'(mRdValid));
    checkOutput("rd_data", 32'(bus.rd_data), 32'(mRdData));
  end

  int grantLog[$];
  int bankLog[$];
  always @(posedge clk) begin
    #1;
    if (bus.start_job) begin
      grantLog.push_back(int'(bus.job_ch));
      bankLog.push_back(int'(bus.job_bank));
    end
  end

  task automatic applyStimulus(input bit v, input int ch, input int data, input bit done,
                               input bit rd, input int idx);
    @(negedge clk);
    bus.valid_in  = v;
    bus.ch_in     = CH_W'(ch);
    bus.sample_in = DATA_WIDTH'(data);
    bus.job_done  = done;
    bus.rd_en     = rd;
    bus.rd_idx    = IDX_W'(idx);
    bus.cfg_we    = 1'b0;
    bus.cfg_ch    = '0;
    bus.cfg_mode  = '0;
    bus.ovf_clear = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic sendSample(input int ch, input int data);
    applyStimulus(1, ch, data, 0, 0, 0);
  endtask

  task automatic fillBlock(input int ch, input int base);
    for (int i = 0; i < BLOCK_SIZE; i++) sendSample(ch, base + i);
  endtask

  task automatic writeMode(input int ch, input logic [1:0] mode);
    idleCycle();
    bus.cfg_we   = 1'b1;
    bus.cfg_ch   = CH_W'(ch);
    bus.cfg_mode = mode;
  endtask

  task automatic clearOvf();
    idleCycle();
    bus.ovf_clear = 1'b1;
  endtask

  task automatic waitStart(input string name, output int n);
    bit found = 0;
    n = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      idleCycle();
      n++;
      if (bus.start_job) found = 1;
    end
    checkOutput(name, 32'(found), 32'd1);
  endtask

  task automatic waitBusy(input string name);
    bit found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      idleCycle();
      if (bus.processing_active) found = 1;
    end
    checkOutput(name, 32'(found), 32'd1);
  endtask

  task automatic finishJob();
    applyStimulus(0, 0, 0, 1, 0, 0);
    idleCycle();
    checkOutput("active_after_done", 32'(bus.processing_active), 32'd0);
  endtask

  task automatic readCheck(input string name, input int idx, input int expected);
    applyStimulus(0, 0, 0, 0, 1, idx);
    idleCycle();
    checkOutput({name, "_valid"}, 32'(bus.rd_valid), 32'd1);
    checkOutput(name, 32'(bus.rd_data), 32'(expected));
  endtask

  task automatic doReset();
    idleCycle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    grantLog.delete();
    bankLog.delete();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bus.valid_in = 0; bus.ch_in = '0; bus.sample_in = '0; bus.cfg_we = 0; bus.cfg_ch = '0;
    bus.cfg_mode = '0; bus.ovf_clear = 0; bus.job_done = 0; bus.rd_en = 0; bus.rd_idx = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_start_job", 32'(bus.start_job), 32'd0);
    checkOutput("rst_active", 32'(bus.processing_active), 32'd0);
    checkOutput("rst_overflow", 32'(bus.overflow), 32'd0);
    checkOutput("rst_blocks_done", 32'(bus.blocks_done), 32'd0);

    $display("[TB] single channel dispatch and readback");
    writeMode(2, MODE_FFT);
    fillBlock(2, 1);
    waitStart("t1_start_seen", n);
    checkOutput("t1_start_latency", 32'(n), 32'd2);
    checkOutput("t1_job_ch", 32'(bus.job_ch), 32'd2);
    checkOutput("t1_job_bank", 32'(bus.job_bank), 32'd0);
    checkOutput("t1_job_mode", 32'(bus.job_mode), 32'd1);
    for (int i = 0; i <= BLOCK_SIZE; i++) begin
      applyStimulus(0, 0, 0, 0, i < BLOCK_SIZE, i % BLOCK_SIZE);
      if (i > 0) begin
        checkOutput("t1_rd_valid", 32'(bus.rd_valid), 32'd1);
        checkOutput("t1_rd_data", 32'(bus.rd_data), 32'(i));
      end
    end
    finishJob();
    checkOutput("t1_blocks_done", 32'(bus.blocks_done), 32'd1);
    writeMode(1, MODE_FFT_IFFT);
    writeMode(3, MODE_BYPASS);

    $display("[TB] round-robin across channels 0, 1, 3");
    doReset();
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      sendSample(0, 'h100 + i);
      sendSample(1, 'h200 + i);
      sendSample(3, 'h300 + i);
    end
    for (int k = 0; k < 3; k++) begin
      waitBusy("t2_busy");
      finishJob();
    end
    checkOutput("t2_grant_count", 32'(grantLog.size()), 32'd3);
    checkOutput("t2_grant0", 32'(grantLog.size() > 0 ? grantLog[0] : 99), 32'd0);
    checkOutput("t2_grant1", 32'(grantLog.size() > 1 ? grantLog[1] : 99), 32'd1);
    checkOutput("t2_grant2", 32'(grantLog.size() > 2 ? grantLog[2] : 99), 32'd3);
    checkOutput("t2_blocks_done", 32'(bus.blocks_done), 32'd3);

    $display("[TB] ping-pong on channel 1");
    doReset();
    fillBlock(1, 'h400);
    fillBlock(1, 'h500);
    idleCycle();
    checkOutput("t3_overflow", 32'(bus.overflow), 32'd0);
    waitBusy("t3_busy0");
    finishJob();
    waitBusy("t3_busy1");
    readCheck("t3_rd_bank1", 3, 'h503);
    finishJob();
    checkOutput("t3_bank0", 32'(bankLog.size() > 0 ? bankLog[0] : 99), 32'd0);
    checkOutput("t3_bank1", 32'(bankLog.size() > 1 ? bankLog[1] : 99), 32'd1);

    $display("[TB] overflow with stalled engine");
    doReset();
    fillBlock(0, 'h600);
    fillBlock(0, 'h700);
    sendSample(0, 'hBEEF);
    idleCycle();
    checkOutput("t4_overflow_set", 32'(bus.overflow), 32'd1);
    finishJob();
    sendSample(0, 'h1234);
    for (int i = 1; i < BLOCK_SIZE; i++) sendSample(0, 'h800 + i);
    finishJob();
    waitBusy("t4_busy");
    checkOutput("t4_job_bank", 32'(bus.job_bank), 32'd0);
    readCheck("t4_rd_idx0", 0, 'h1234);
    readCheck("t4_rd_idx1", 1, 'h801);
    clearOvf();
    idleCycle();
    checkOutput("t4_overflow_clr", 32'(bus.overflow), 32'd0);
    finishJob();

    $display("[TB] release and write in the same cycle");
    doReset();
    fillBlock(0, 'h900);
    fillBlock(0, 'hA00);
    applyStimulus(1, 0, 'h5A5A, 1, 0, 0);
    idleCycle();
    checkOutput("t5_overflow", 32'(bus.overflow), 32'd0);
    for (int i = 1; i < BLOCK_SIZE; i++) sendSample(0, 'hB00 + i);
    finishJob();
    waitBusy("t5_busy");
    checkOutput("t5_job_bank", 32'(bus.job_bank), 32'd0);
    readCheck("t5_rd_idx0", 0, 'h5A5A);
    finishJob();

    $display("[TB] reset in the middle of a job");
    fillBlock(2, 'hC00);
    waitBusy("t6_busy");
    doReset();
    checkOutput("t6_start_job", 32'(bus.start_job), 32'd0);
    checkOutput("t6_active", 32'(bus.processing_active), 32'd0);
    checkOutput("t6_overflow", 32'(bus.overflow), 32'd0);
    checkOutput("t6_blocks_done", 32'(bus.blocks_done), 32'd0);
    for (int i = 0; i < BLOCK_SIZE - 1; i++) sendSample(2, 'hD00 + i);
    repeat (4) idleCycle();
    checkOutput("t6_no_early_job", 32'(bus.processing_active), 32'd0);
    sendSample(2, 'hD0F);
    waitStart("t6_start_seen", n);
    checkOutput("t6_start_latency", 32'(n), 32'd2);
    checkOutput("t6_job_bank", 32'(bus.job_bank), 32'd0);
    readCheck("t6_rd_idx15", 15, 'hD0F);
    finishJob();

    repeat (2) idleCycle();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/dsp_block_scheduler.md
# dsp_block_scheduler

Multi-channel successor to the single-stream input-buffer/controller pair in the DSP accelerator chiplet. It collects interleaved samples from NUM_CH channels into per-channel ping-pong banks of BLOCK_SIZE words and dispatches completed blocks one at a time to a shared processing engine (FIR/FFT/IFFT) through a start/done handshake. Each channel has its own programmable processing mode. Block sits between the sample ingress and the processing cores. The engine reads block data back through a registered read port.

## Interface
- DATA_WIDTH, 16, sample width in bits
- NUM_CH, 4, channel count (≥2, power of two)
- BLOCK_SIZE, 16, samples per block (power of two)
- MODE_W, 2, per-channel mode width (00 FIR LPF, 01 FFT, 10 FFT+IFFT, 11 bypass)

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- valid_in  in  1  sample strobe
- ch_in  in  $clog2(NUM_CH)  channel of sample_in
- sample_in  in  DATA_WIDTH  sample
- cfg_we  in  1  mode write strobe
- cfg_ch  in  $clog2(NUM_CH)  channel written
- cfg_mode  in  MODE_W  new mode
- ovf_clear  in  1  clears all overflow flags
- start_job  out  1  one-cycle dispatch pulse
- job_ch  out  $clog2(NUM_CH)  channel of current job
- job_bank  out  1  bank of current job
- job_mode  out  MODE_W  mode latched at dispatch
- job_done  in  1  engine completion
- rd_en  in  1  engine read request
- rd_idx  in  $clog2(BLOCK_SIZE)  sample index within current job's bank
- rd_data  out  DATA_WIDTH  read data
- rd_valid  out  1  rd_data valid
- processing_active  out  1  high in BUSY
- overflow  out  NUM_CH  sticky per-channel drop flags
- blocks_done  out  16  completed-job counter

## Operation
- Reset: all outputs 0. All write pointers, wr_bank, serve_bank, and occupancy flags 0. Every channel's mode is 00. Round-robin pointer is 0. State is IDLE.
- Ingress: on valid_in, write sample_in to mem[ch][wr_bank[ch]][wr_ptr[ch]] and increment wr_ptr.
  - At wr_ptr = BLOCK_SIZE-1: set occupied[ch][wr_bank], toggle wr_bank, wr_ptr wraps to 0.
  - If occupied[ch][wr_bank[ch]] is set when a sample arrives: drop the sample, set overflow[ch], leave the pointer unchanged.
- Release and write in the same cycle on the same bank: the release wins and the sample is accepted.
- cfg_we updates mode[cfg_ch] at the next edge. A running job keeps its latched job_mode.
- ovf_clear clears all overflow bits. A new overflow in the same cycle wins (bit stays set).
- Scheduler FSM (IDLE, BUSY):
  - A channel is eligible when occupied[ch][serve_bank[ch]] is set.
  - IDLE: if any channel is eligible, grant the first eligible channel searching from rr_ptr upward with wrap. Register job_ch, job_bank = serve_bank[ch], and job_mode = mode[ch]. Pulse start_job. Go to BUSY. Set rr_ptr = granted+1 mod NUM_CH.
  - BUSY: job_done clears occupied[job_ch][job_bank], toggles serve_bank[job_ch], increments blocks_done (wraps mod 2^16), and returns to IDLE.
  - job_done in IDLE is ignored.
- Blocks in a channel are served in fill order: bank 0, 1, 0, …
- Read port: rd_en in BUSY returns mem[job_ch][job_bank][rd_idx] on rd_data with rd_valid one cycle later. rd_en in IDLE gives rd_valid = 0 and rd_data holds its value.
- Reset mid-job: everything returns to reset values and buffered data is discarded.

## Timing
- Last sample of a block at edge E0 sets occupied visibly after E0. If IDLE, start_job is high in the cycle after E1 (2-edge latency from last sample).
- start_job is exactly one cycle wide. job_ch, job_bank, and job_mode are stable from start_job until the next grant.
- job_done sampled at edge Ed: processing_active drops after Ed. The earliest next start_job is after Ed+1.
- Read latency is 1 cycle, fully pipelined (one read per cycle).
- Ingress accepts one sample per cycle regardless of FSM state.

## Structure
- Package dsp_sched_pkg holds:
  - state enum {IDLE, BUSY}
  - mode encoding constants MODE_FIR, MODE_FFT, MODE_FFT_IFFT, MODE_BYPASS
  - localparam widths derived from NUM_CH and BLOCK_SIZE
- Sub-module pingpong_bank: one channel's two BLOCK_SIZE×DATA_WIDTH banks, write pointer, wr_bank, and occupancy. Instantiated NUM_CH times via generate.
- Top-level scheduler holds the FSM, round-robin arbiter, mode registers, read mux/register, and counter.

## Test plan
- Single channel: 16 samples on ch 2 (values 1..16), mode written 01 → start_job 2 cycles after last sample with job_ch=2, job_bank=0, job_mode=01. Reads idx 0..15 return 1..16 one cycle later.
- Round-robin: ch 0, 1, 3 fill simultaneously (interleaved) → grants in order 0, 1, 3, each after the prior job_done. blocks_done=3.
- Ping-pong: ch 1 fills banks 0 and 1 before any job_done → bank 0 served first, then bank 1. No overflow.
- Overflow: ch 0 fills both banks with engine stalled, then a 33rd sample (value 0xBEEF) → dropped, overflow[0]=1. After job_done, the next sample goes to bank 0, idx 0. ovf_clear → overflow=0.
- Simultaneous release + write: job_done for ch 0 bank 0 in the same cycle as a sample arriving at full bank 0 → sample accepted at idx 0, no overflow.
- Reset mid-job: reset in BUSY → start_job=0, processing_active=0, overflow=0, blocks_done=0. The next block needs 16 fresh samples.
